// File: rtl/answer_msg_seg7.sv
// Status-message driver for the passcode lock's seven-segment digits: latches an answer code,
// blinks its message BLINK_COUNT times, then holds it. Optional AUTO_CLEAR_EN blanks after HOLD_CLKS.
module answer_msg_seg7 #(
    parameter int NUM_DIGITS  = 2,
    parameter int BLINK_CLKS  = 6_250_000,
    parameter int BLINK_COUNT = 3,
    parameter int HOLD_CLKS   = 125_000_000
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic [2:0]              i_Answer,
    input  logic                    i_Load,
    output logic [7*NUM_DIGITS-1:0] o_Segments,
    output logic                    o_Busy
);

    localparam int PH_W = (BLINK_CLKS > 1) ? $clog2(BLINK_CLKS) : 1;
    localparam int PR_W = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(BLINK_CLKS - 1);
    localparam logic [PR_W-1:0] PR_LAST = PR_W'(BLINK_COUNT - 1);

    localparam logic [6:0] G_Y = 7'h3B, G_E = 7'h4F, G_S = 7'h5B, G_N = 7'h15;
    localparam logic [6:0] G_O = 7'h1D, G_R = 7'h05, G_BIG_O = 7'h7E, G_P = 7'h67;
    localparam logic [6:0] G_BL = 7'h00;

    typedef enum logic [1:0] {IDLE, BLINK_ON, BLINK_OFF, SHOW} state_t;

    state_t                    state, state_nxt;
    logic [2:0]                code, code_nxt;
    logic [PH_W-1:0]           phase, phase_nxt;
    logic [PR_W-1:0]           pair, pair_nxt;
    logic [7*NUM_DIGITS-1:0]   seg_nxt;
    logic                      busy_nxt;
`ifdef AUTO_CLEAR_EN
    localparam int HD_W = (HOLD_CLKS > 1) ? $clog2(HOLD_CLKS) : 1;
    localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CLKS - 1);
    logic [HD_W-1:0]           hold, hold_nxt;
`endif

    // Message is four characters wide; character i lands on digit i.
    function automatic logic [6:0] char_glyph(input logic [2:0] c, input int idx);
        logic [27:0] msg;
        case (c)
            3'd1:    msg = {G_Y, G_E, G_S, G_BL};
            3'd2:    msg = {G_N, G_O, G_BL, G_BL};
            3'd3:    msg = {G_E, G_R, G_R, G_BL};
            3'd4:    msg = {G_BIG_O, G_P, G_E, G_N};
            default: msg = '0;
        endcase
        return msg[27-7*idx -: 7];
    endfunction

    function automatic logic [7*NUM_DIGITS-1:0] msg_segs(input logic [2:0] c);
        logic [7*NUM_DIGITS-1:0] s;
        s = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            s[7*(NUM_DIGITS-1-d) +: 7] = char_glyph(c, d);
        end
        return s;
    endfunction

    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        phase_nxt = phase;
        pair_nxt  = pair;
`ifdef AUTO_CLEAR_EN
        hold_nxt  = hold;
`endif
        if (i_Load) begin
            phase_nxt = '0;
            pair_nxt  = '0;
`ifdef AUTO_CLEAR_EN
            hold_nxt  = '0;
`endif
            if (i_Answer == 3'd0) begin
                state_nxt = IDLE;
                code_nxt  = 3'd0;
            end else begin
                code_nxt  = i_Answer;
                state_nxt = (BLINK_COUNT == 0) ? SHOW : BLINK_ON;
            end
        end else begin
            case (state)
                BLINK_ON: begin
                    if (phase == PH_LAST) begin
                        phase_nxt = '0;
                        state_nxt = BLINK_OFF;
                    end else begin
                        phase_nxt = phase + 1'b1;
                    end
                end
                BLINK_OFF: begin
                    if (phase == PH_LAST) begin
                        phase_nxt = '0;
                        if (pair == PR_LAST) begin
                            pair_nxt  = '0;
                            state_nxt = SHOW;
                        end else begin
                            pair_nxt  = pair + 1'b1;
                            state_nxt = BLINK_ON;
                        end
                    end else begin
                        phase_nxt = phase + 1'b1;
                    end
                end
`ifdef AUTO_CLEAR_EN
                SHOW: begin
                    if (hold == HD_LAST) begin
                        hold_nxt  = '0;
                        state_nxt = IDLE;
                        code_nxt  = 3'd0;
                    end else begin
                        hold_nxt  = hold + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end

        // Outputs are decoded from the next state so they move on the same edge as the FSM.
        seg_nxt  = '0;
        busy_nxt = 1'b0;
        case (state_nxt)
            BLINK_ON:  begin seg_nxt = msg_segs(code_nxt); busy_nxt = 1'b1; end
            BLINK_OFF: busy_nxt = 1'b1;
            SHOW:      seg_nxt = msg_segs(code_nxt);
            default:   ;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state      <= IDLE;
            code       <= 3'd0;
            phase      <= '0;
            pair       <= '0;
            o_Segments <= '0;
            o_Busy     <= 1'b0;
`ifdef AUTO_CLEAR_EN
            hold       <= '0;
`endif
        end else begin
            state      <= state_nxt;
            code       <= code_nxt;
            phase      <= phase_nxt;
            pair       <= pair_nxt;
            o_Segments <= seg_nxt;
            o_Busy     <= busy_nxt;
`ifdef AUTO_CLEAR_EN
            hold       <= hold_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_answer_msg_seg7.sv
// Directed bench for answer_msg_seg7: a 2-digit blinking instance and a 4-digit no-blink instance.
module tb_answer_msg_seg7;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  answer;
    logic        load;
    logic [13:0] seg2;
    logic        busy2;
    logic [27:0] seg4;
    logic        busy4;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [27:0] BLANK = 28'h0;
    localparam logic [27:0] YES2  = 28'({7'h3B, 7'h4F});
    localparam logic [27:0] YES4  = {7'h3B, 7'h4F, 7'h5B, 7'h00};
    localparam logic [27:0] OPEN2 = 28'({7'h7E, 7'h67});
    localparam logic [27:0] OPEN4 = {7'h7E, 7'h67, 7'h4F, 7'h15};
    localparam logic [27:0] NO2   = 28'({7'h15, 7'h1D});
    localparam logic [27:0] NO4   = {7'h15, 7'h1D, 7'h00, 7'h00};
    localparam logic [27:0] ERR2  = 28'({7'h4F, 7'h05});

    answer_msg_seg7 #(.NUM_DIGITS(2), .BLINK_CLKS(4), .BLINK_COUNT(2), .HOLD_CLKS(10)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Answer(answer), .i_Load(load),
        .o_Segments(seg2), .o_Busy(busy2)
    );

    answer_msg_seg7 #(.NUM_DIGITS(4), .BLINK_CLKS(4), .BLINK_COUNT(0), .HOLD_CLKS(10)) dut4 (
        .i_Clk(clk), .i_Rst(rst), .i_Answer(answer), .i_Load(load),
        .o_Segments(seg4), .o_Busy(busy4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [27:0] act, input logic [27:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [2:0] c);
        answer = c;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    // Expected 2-digit display k edges after a load with BLINK_CLKS=4, BLINK_COUNT=2.
    function automatic logic [27:0] blink_exp(input int k, input logic [27:0] glyph);
        if (k >= 16 || ((k / 4) % 2) == 0) return glyph;
        return BLANK;
    endfunction

    initial begin
        rst = 1'b1; load = 1'b0; answer = 3'd0;
        tick(); tick();
        rst = 1'b0;
        check("reset_seg2", 28'(seg2), BLANK);
        check("reset_busy2", 28'(busy2), 28'd0);
        check("reset_seg4", seg4, BLANK);

        do_load(3'd0);
        check("code0_seg2", 28'(seg2), BLANK);
        check("code0_busy2", 28'(busy2), 28'd0);

        do_load(3'd1);
        check("nob_yes_seg4", seg4, YES4);
        check("nob_yes_busy4", 28'(busy4), 28'd0);
        for (int k = 0; k <= 16; k++) begin
            check($sformatf("yes_seg_k%0d", k), 28'(seg2), blink_exp(k, YES2));
            check($sformatf("yes_busy_k%0d", k), 28'(busy2), (k < 16) ? 28'd1 : 28'd0);
            if (k < 16) tick();
        end

        do_load(3'd0);
        check("show_clear_seg", 28'(seg2), BLANK);
        check("show_clear_busy", 28'(busy2), 28'd0);

        do_load(3'd4);
        check("open_seg2", 28'(seg2), OPEN2);
        check("open_seg4", seg4, OPEN4);
        do_load(3'd2);
        check("no_seg2", 28'(seg2), NO2);
        check("no_seg4", seg4, NO4);

        do_load(3'd5);
        check("code5_seg", 28'(seg2), BLANK);
        check("code5_busy", 28'(busy2), 28'd1);

        do_load(3'd1);
        repeat (12) tick();
        check("pre_reload_seg", 28'(seg2), BLANK);
        check("pre_reload_busy", 28'(busy2), 28'd1);
        do_load(3'd3);
        for (int k = 0; k <= 16; k++) begin
            check($sformatf("err_seg_k%0d", k), 28'(seg2), blink_exp(k, ERR2));
            check($sformatf("err_busy_k%0d", k), 28'(busy2), (k < 16) ? 28'd1 : 28'd0);
            if (k < 16) tick();
        end

`ifdef AUTO_CLEAR_EN
        repeat (9) tick();
        check("hold9_seg", 28'(seg2), ERR2);
        tick();
        check("autoclear_seg", 28'(seg2), BLANK);
        check("autoclear_busy", 28'(busy2), 28'd0);
`else
        repeat (1000) tick();
        check("hold1000_seg", 28'(seg2), ERR2);
        check("hold1000_busy", 28'(busy2), 28'd0);
`endif

        do_load(3'd1);
        tick(); tick();
        check("prerst_seg", 28'(seg2), YES2);
        rst = 1'b1; load = 1'b1; answer = 3'd3;
        tick();
        rst = 1'b0; load = 1'b0;
        check("rstprio_seg2", 28'(seg2), BLANK);
        check("rstprio_busy2", 28'(busy2), 28'd0);
        check("rstprio_seg4", seg4, BLANK);
        repeat (5) tick();
        check("idle_after_rst", 28'(seg2), BLANK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
